pipe_seq_ctrl: RTL and testbench

Parametrised control sequencer for a multi-stage arithmetic datapath (capture, min/max, delta, per-channel enables). It generalises the fixed five-state controller:
- the stage count is a parameter;
- an input valid/ready handshake and an output valid/ready handshake with backpressure are added;
- a runtime mode selects one-item-at-a-time (sequential) or fully overlapped (pipelined) operation;
- completed results are counted.
It drives per-stage register enables only. No datapath logic lives here.

---
 rtl/pipe_seq_ctrl_pkg.sv | 8 +
 rtl/pipe_seq_ctrl_if.sv | 29 ++
 rtl/pipe_seq_ctrl_evt_counter.sv | 27 ++
 rtl/pipe_seq_ctrl.sv | 87 ++++++++
 tb/tb_pipe_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared constants for the pipelined sequencer: mode encodings and the stage-count ceiling.
package pipe_seq_ctrl_pkg;

    localparam logic MODE_SEQ   = 1'b0;
    localparam logic MODE_PIPE  = 1'b1;
    localparam int   MAX_STAGES = 16;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Handshake and stage-enable bundle between the sequencer (master) and its datapath/environment (slave).
interface pipe_seq_ctrl_if #(
    parameter int N_STAGES = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                load_en;
    logic [N_STAGES-1:0] stage_en;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output load_en,
        output stage_en,
        output out_valid
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  load_en,
        input  stage_en,
        input  out_valid
    );
endinterface

// File: rtl/pipe_seq_ctrl_evt_counter.sv
// Wrapping event counter, clear wins over increment.
// Latency: count visible one cycle after the event; no backpressure.
module pipe_seq_ctrl_evt_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Token-shift sequencer driving per-stage enables; result after N_STAGES+1 cycles from accept.
// A held result (out_valid & ~out_ready) freezes every stage and, in pipelined mode, the input.
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             cnt_clr,
    pipe_seq_ctrl_if.master  bus,
    output logic             busy,
    output logic [CNT_W-1:0] item_cnt
);

    if (N_STAGES < 1 || N_STAGES > MAX_STAGES) begin : g_bad_n_stages
        $error("pipe_seq_ctrl: N_STAGES out of range 1..16");
    end

    logic [N_STAGES-1:0] r_tok;
    logic [N_STAGES-1:0] w_tok_nxt;
    logic                r_out_valid;
    logic                r_mode;
    logic                w_adv;
    logic                w_idle;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_done;

    assign w_adv  = ~(r_out_valid & ~bus.out_ready);
    assign w_idle = (r_tok == '0) & ~r_out_valid;

    // Sequential mode admits a new item only once the previous result has left.
    always_comb begin
        w_in_ready = 1'b0;
        if (rst_n) begin
            w_in_ready = (r_mode == MODE_PIPE) ? w_adv : w_idle;
        end
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_done   = r_out_valid & bus.out_ready;

    always_comb begin
        w_tok_nxt    = '0;
        w_tok_nxt[0] = w_accept;
        for (int k = 1; k < N_STAGES; k++) begin
            w_tok_nxt[k] = r_tok[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tok       <= '0;
            r_out_valid <= 1'b0;
            r_mode      <= MODE_SEQ;
        end else begin
            if (w_adv) begin
                r_tok       <= w_tok_nxt;
                r_out_valid <= r_tok[N_STAGES-1];
            end
            // Mode is only taken while empty so in-flight items never see a policy change.
            if (w_idle) begin
                r_mode <= mode;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.load_en   = w_accept;
    assign bus.stage_en  = rst_n ? (r_tok & {N_STAGES{w_adv}}) : '0;
    assign bus.out_valid = r_out_valid;
    assign busy          = ~w_idle;

    pipe_seq_ctrl_evt_counter #(
        .W (CNT_W)
    ) u_item_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (cnt_clr),
        .i_inc (w_done),
        .o_cnt (item_cnt)
    );

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: item-position model checked every cycle plus directed literal expectations.
module tb_pipe_seq_ctrl;
    import pipe_seq_ctrl_pkg::*;

    localparam int NS = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          cnt_clr;
    logic          busy;
    logic [CW-1:0] item_cnt;
    int            checks = 0;
    int            errors = 0;

    pipe_seq_ctrl_if #(.N_STAGES(NS)) bus ();

    pipe_seq_ctrl #(
        .N_STAGES (NS),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .cnt_clr  (cnt_clr),
        .bus      (bus),
        .busy     (busy),
        .item_cnt (item_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        obs();
        while (busy && n < 50) begin
            nxt();
            obs();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        nxt();
    endtask

    // Model: each in-flight item is its stage index; index NS means sitting in the result register.
    initial begin : compare
        int         pos[$];
        logic       m_mode;
        int         m_cnt;
        logic       has_out;
        logic       adv;
        logic       exp_ir;
        logic       exp_ld;
        logic [NS-1:0] exp_se;
        m_mode = MODE_SEQ;
        m_cnt  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            has_out = 1'b0;
            exp_se  = '0;
            foreach (pos[i]) begin
                if (pos[i] == NS) has_out = 1'b1;
                else              exp_se[pos[i]] = 1'b1;
            end
            adv    = !(has_out && !bus.out_ready);
            exp_ir = rst_n && (m_mode ? adv : (pos.size() == 0));
            exp_ld = exp_ir && bus.in_valid;
            if (!rst_n || !adv) exp_se = '0;
            chk("m_in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_ir});
            chk("m_load_en",   {31'd0, bus.load_en},   {31'd0, exp_ld});
            chk("m_stage_en",  {28'd0, bus.stage_en},  {28'd0, exp_se});
            chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, has_out});
            chk("m_busy",      {31'd0, busy},          {31'd0, pos.size() != 0});
            chk("m_item_cnt",  {24'd0, item_cnt},      m_cnt);
            if (!rst_n) begin
                pos.delete();
                m_mode = MODE_SEQ;
                m_cnt  = 0;
            end else begin
                if (cnt_clr)                         m_cnt = 0;
                else if (has_out && bus.out_ready)   m_cnt = (m_cnt + 1) % (1 << CW);
                if (pos.size() == 0) m_mode = mode;
                if (adv) begin
                    if (has_out) void'(pos.pop_front());
                    foreach (pos[i]) pos[i]++;
                    if (exp_ld) pos.push_back(0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          acc;
        int          hs;
        logic [NS-1:0] se_exp;
        rst_n         = 1'b0;
        mode          = MODE_SEQ;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;

        // Reset held with traffic offered
        for (int c = 0; c < 2; c++) begin
            obs();
            chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("rst_load_en",  {31'd0, bus.load_en},  32'd0);
            chk("rst_stage_en", {28'd0, bus.stage_en}, 32'd0);
            if (c == 1) begin
                chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
                chk("rst_busy",      {31'd0, busy},          32'd0);
                chk("rst_item_cnt",  {24'd0, item_cnt},      32'd0);
            end
            nxt();
        end

        // Reset in the middle of three in-flight items
        rst_n = 1'b1; bus.in_valid = 1'b0; mode = MODE_PIPE;
        obs(); nxt();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            obs();
            chk("fill_load_en", {31'd0, bus.load_en}, 32'd1);
            nxt();
        end
        bus.in_valid = 1'b0; rst_n = 1'b0;
        obs();
        chk("midrst_stage_en", {28'd0, bus.stage_en}, 32'd0);
        chk("midrst_busy",     {31'd0, busy},         32'd1);
        nxt();
        rst_n = 1'b1; mode = MODE_SEQ;
        for (int c = 0; c < 8; c++) begin
            obs();
            chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
            if (c == 0) chk("flush_busy", {31'd0, busy}, 32'd0);
            nxt();
        end

        // Sequential single item
        for (int t = 0; t < 7; t++) begin
            bus.in_valid = (t == 0);
            obs();
            se_exp = '0;
            if (t >= 1 && t <= NS) se_exp[t-1] = 1'b1;
            chk("seq_load_en",   {31'd0, bus.load_en},   {31'd0, t == 0});
            chk("seq_stage_en",  {28'd0, bus.stage_en},  {28'd0, se_exp});
            chk("seq_out_valid", {31'd0, bus.out_valid}, {31'd0, t == 5});
            chk("seq_in_ready",  {31'd0, bus.in_ready},  {31'd0, (t == 0) || (t == 6)});
            if (t == 6) chk("seq_item_cnt", {24'd0, item_cnt}, 32'd1);
            nxt();
        end

        // Pipelined stream of 8
        mode = MODE_PIPE; cnt_clr = 1'b1; bus.in_valid = 1'b0;
        obs(); nxt();
        cnt_clr = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.in_valid = (c < 8);
            obs();
            if (c < 8) chk("pipe_in_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("pipe_out_valid", {31'd0, bus.out_valid}, {31'd0, (c >= 5) && (c <= 12)});
            if (c == 13) begin
                chk("pipe_busy",     {31'd0, busy},     32'd0);
                chk("pipe_item_cnt", {24'd0, item_cnt}, 32'd8);
            end
            nxt();
        end

        // Backpressure window on the output
        cnt_clr = 1'b1; bus.in_valid = 1'b0;
        obs(); nxt();
        cnt_clr = 1'b0; acc = 0; hs = 0;
        for (int c = 0; c < 30; c++) begin
            bus.in_valid  = (acc < 8);
            bus.out_ready = !((c >= 6) && (c <= 8));
            obs();
            if (bus.load_en) acc++;
            if (bus.out_valid && bus.out_ready) hs++;
            if (c >= 6 && c <= 8) begin
                chk("bp_stage_en",  {28'd0, bus.stage_en},  32'd0);
                chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
                chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            if (c == 9) chk("bp_item_cnt_mid", {24'd0, item_cnt}, 32'd1);
            nxt();
        end
        bus.out_ready = 1'b1;
        chk("bp_accepts",    acc, 32'd8);
        chk("bp_handshakes", hs,  32'd8);
        chk("bp_item_cnt",   {24'd0, item_cnt}, 32'd8);

        // Mode switch requested while busy
        for (int c = 0; c < 27; c++) begin
            bus.in_valid = (c <= 5) || (c >= 11);
            mode         = (c >= 3) ? MODE_SEQ : MODE_PIPE;
            obs();
            if (c >= 3 && c <= 5) chk("msw_in_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("msw_load_en", {31'd0, bus.load_en},
                {31'd0, (c <= 5) || (c == 11) || (c == 17) || (c == 23)});
            nxt();
        end
        drain("msw_drain");

        // Counter wrap after 256 completions
        mode = MODE_PIPE; cnt_clr = 1'b1; bus.in_valid = 1'b0;
        obs(); nxt();
        cnt_clr = 1'b0;
        for (int c = 0; c < 262; c++) begin
            bus.in_valid = (c < 256);
            obs();
            if (c == 260) chk("wrap_cnt_255", {24'd0, item_cnt}, 32'd255);
            if (c == 261) begin
                chk("wrap_cnt_0", {24'd0, item_cnt}, 32'd0);
                chk("wrap_busy",  {31'd0, busy},     32'd0);
            end
            nxt();
        end

        // Clear coincident with a completion
        for (int c = 0; c < 9; c++) begin
            bus.in_valid = (c < 3);
            cnt_clr      = (c == 7);
            obs();
            if (c == 7) begin
                chk("clr_out_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("clr_cnt_pre",   {24'd0, item_cnt},      32'd2);
            end
            if (c == 8) chk("clr_cnt_post", {24'd0, item_cnt}, 32'd0);
            nxt();
        end
        cnt_clr = 1'b0;
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
